ps2_keycode_rx: RTL and testbench
=================================

Name: ps2_keycode_rx

Overview:
Producer end of the 16-bit keycode interface consumed by the ball motion block. It receives PS/2 keyboard frames (scan code set 2) and decodes make, break (F0) and extended (E0) prefixes. It then translates the result to the USB HID usage codes the downstream logic already expects. It runs on the system clock and sits between the PS/2 pins and every keycode consumer.

Parameters:
TIMEOUT_CYCLES, 10000, Clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted (200 us at 50 MHz).
TMO_W, 14, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
Clk  input  1  system clock; every register in the block is clocked on its rising edge.
Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to Clk.
ps2_data  input  1  raw PS/2 data pin, asynchronous to Clk.
keycode  output  16  HID usage of the currently held mapped key; 16'h0000 when no key is held; upper byte is always 8'h00.
key_event  output  1  one-cycle pulse in the cycle keycode changes value.
frame_err  output  1  one-cycle pulse when a frame is dropped (bad start, bad stop, parity fail or timeout).

Behaviour:
- Reset values: keycode=16'h0000, key_event=0, frame_err=0, FSM=IDLE, brk=0, ext=0, shift register=0, timeout counter=0.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer. fall = prev_sync & ~sync, registered once. All sampling happens only in cycles where fall=1.
- Frame FSM states:
  - IDLE: on fall, if data=0 (start bit) go to DATA with bit count 0. If data=1, pulse frame_err and stay in IDLE.
  - DATA: on each fall, shift data in LSB-first. After 8 bits go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, if stop=1 and parity is good (odd over the 8 data bits plus the parity bit), assert byte_valid for 1 cycle. Otherwise pulse frame_err. Return to IDLE in either case.
- Timeout: the counter clears on every fall and increments in every non-IDLE cycle without one. On reaching TIMEOUT_CYCLES, go to IDLE and pulse frame_err. Partial bits are discarded. brk and ext are retained.
- Byte decoder, acting on byte_valid:
  - F0: set brk.
  - E0: set ext.
  - Any other byte: look up hid = map(ext, byte), then clear brk and ext.
    - If hid != 0 and brk=0: keycode <= {8'h00, hid}.
    - If hid != 0, brk=1 and keycode matches hid: keycode <= 0.
    - Break of a key that is not current: ignored.
    - Unmapped byte (hid=0): keycode unchanged.
- Rollover: the newest make replaces keycode. Releasing the older key does not clear keycode.
- key_event is asserted in the same cycle keycode updates, and only if the value actually differs from the previous one. Repeated typematic makes of the held key produce no event.
- Latency: keycode updates 2 Clk cycles after the cycle in which the stop-bit fall is seen (byte_valid register, then keycode register).
- Map, non-extended: 1C->04 (A), 23->07 (D), 1B->16 (S), 1D->1A (W), 29->2C (space), 5A->28 (enter), 76->29 (esc).
- Map, extended: 75->52 (up), 72->51 (down), 6B->50 (left), 74->4F (right).
- Reset asserted mid-frame: the next cycle is in reset state. A subsequent partial frame ends via timeout or a bad start bit and never produces a key.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: parity is checked as described above, and a failure drops the byte and pulses frame_err.
- Undefined: the parity bit is sampled but ignored. Only start, stop and timeout can raise frame_err.

Decomposition:
- Package ps2_pkg holds:
  - the frame state enum (IDLE, DATA, PARITY, STOP);
  - localparams BRK_CODE=8'hF0 and EXT_CODE=8'hE0;
  - the HID constants for A/D/S/W/space/enter/esc/arrows.
- Sub-module ps2_hid_map: combinational lookup with inputs (ext, scan[7:0]) and output hid[7:0]; unmapped codes return 8'h00.

Test Plan:
- Frame 1C with good parity -> keycode=16'h0004, key_event pulses once, 2 cycles after the stop-bit fall.
- Frames 1C, F0, 1C -> keycode goes 0x0004 then 0x0000, with two key_event pulses total.
- Frames E0, 75, then E0, F0, 75 -> keycode 0x0052, then 0x0000.
- Frames 1D, 23, F0, 1D -> keycode 0x001A, then 0x0007, and stays at 0x0007 after the break of 1D.
- Frame 1B with flipped parity -> with PS2_PARITY_CHECK_EN defined, frame_err=1 for 1 cycle and keycode unchanged; with it undefined, keycode=0x0016.
- 5 bits of a frame, then a 12000-cycle stall, then a clean frame 23 -> one frame_err pulse, then keycode=0x0007.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

   localparam logic [7:0] BRK_CODE  = 8'hF0;
   localparam logic [7:0] EXT_CODE  = 8'hE0;

   localparam logic [7:0] HID_A     = 8'h04;
   localparam logic [7:0] HID_D     = 8'h07;
   localparam logic [7:0] HID_S     = 8'h16;
   localparam logic [7:0] HID_W     = 8'h1A;
   localparam logic [7:0] HID_SPACE = 8'h2C;
   localparam logic [7:0] HID_ENTER = 8'h28;
   localparam logic [7:0] HID_ESC   = 8'h29;
   localparam logic [7:0] HID_UP    = 8'h52;
   localparam logic [7:0] HID_DOWN  = 8'h51;
   localparam logic [7:0] HID_LEFT  = 8'h50;
   localparam logic [7:0] HID_RIGHT = 8'h4F;

endpackage

// File: rtl/ps2_hid_map.sv
// Scan code set 2 to USB HID usage lookup; unmapped codes give 8'h00.
module ps2_hid_map
   import ps2_pkg::*;
(
   input  logic       ext,
   input  logic [7:0] scan,
   output logic [7:0] hid
);

   always_comb begin
      hid = 8'h00;
      if (ext) begin
         case (scan)
            8'h75:   hid = HID_UP;
            8'h72:   hid = HID_DOWN;
            8'h6B:   hid = HID_LEFT;
            8'h74:   hid = HID_RIGHT;
            default: hid = 8'h00;
         endcase
      end else begin
         case (scan)
            8'h1C:   hid = HID_A;
            8'h23:   hid = HID_D;
            8'h1B:   hid = HID_S;
            8'h1D:   hid = HID_W;
            8'h29:   hid = HID_SPACE;
            8'h5A:   hid = HID_ENTER;
            8'h76:   hid = HID_ESC;
            default: hid = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 frame receiver and make/break decoder producing the held key's HID usage.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_keycode_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10000,
   parameter int TMO_W          = 14
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keycode,
   output logic        key_event,
   output logic        frame_err
);

   // clk_sync[1] is the synchronized level, clk_sync[2] its previous value
   logic [2:0]       clk_sync;
   logic [1:0]       dat_sync;
   logic             fall, dat;
   frame_state_t     state, state_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             par, par_nxt, par_ok;
   logic [TMO_W-1:0] tmo, tmo_nxt;
   logic             byte_valid, byte_valid_nxt, err_nxt;
   logic             brk, brk_nxt, ext, ext_nxt;
   logic [7:0]       hid;
   logic [15:0]      key_nxt;

   assign dat = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^{shreg, par};
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      state_nxt      = state;
      bit_cnt_nxt    = bit_cnt;
      shreg_nxt      = shreg;
      par_nxt        = par;
      tmo_nxt        = tmo;
      byte_valid_nxt = 1'b0;
      err_nxt        = 1'b0;
      if (fall)
         tmo_nxt = '0;
      else if (state != IDLE)
         tmo_nxt = tmo + 1'b1;
      case (state)
         IDLE: if (fall) begin
            if (!dat) begin
               state_nxt   = DATA;
               bit_cnt_nxt = '0;
            end else
               err_nxt = 1'b1;
         end
         DATA: if (fall) begin
            shreg_nxt   = {dat, shreg[7:1]};
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state_nxt = PARITY;
         end
         PARITY: if (fall) begin
            par_nxt   = dat;
            state_nxt = STOP;
         end
         STOP: if (fall) begin
            state_nxt = IDLE;
            if (dat && par_ok) byte_valid_nxt = 1'b1;
            else               err_nxt        = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // stalled device: abandon the partial frame, keep prefix flags
      if (!fall && state != IDLE && tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         state_nxt = IDLE;
         tmo_nxt   = '0;
         err_nxt   = 1'b1;
      end
   end

   ps2_hid_map u_map (
      .ext  (ext),
      .scan (shreg),
      .hid  (hid)
   );

   always_comb begin
      key_nxt = keycode;
      brk_nxt = brk;
      ext_nxt = ext;
      if (byte_valid) begin
         if (shreg == BRK_CODE)
            brk_nxt = 1'b1;
         else if (shreg == EXT_CODE)
            ext_nxt = 1'b1;
         else begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
            if (hid != 8'h00) begin
               if (!brk)                         key_nxt = {8'h00, hid};
               else if (keycode == {8'h00, hid}) key_nxt = 16'h0000;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_sync   <= '0;
         dat_sync   <= '0;
         fall       <= 1'b0;
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         tmo        <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         brk        <= 1'b0;
         ext        <= 1'b0;
         keycode    <= 16'h0000;
         key_event  <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[1:0], ps2_clk};
         dat_sync   <= {dat_sync[0], ps2_data};
         fall       <= clk_sync[2] & ~clk_sync[1];
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shreg      <= shreg_nxt;
         par        <= par_nxt;
         tmo        <= tmo_nxt;
         byte_valid <= byte_valid_nxt;
         frame_err  <= err_nxt;
         brk        <= brk_nxt;
         ext        <= ext_nxt;
         keycode    <= key_nxt;
         key_event  <= (key_nxt != keycode);
      end
   end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed and randomized PS/2 frames checked against a byte-level key model.
module tb_ps2_keycode_rx;

   localparam int HALF = 20;

   logic        Clk = 1'b0, Reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [15:0] keycode;
   logic        key_event, frame_err;

   ps2_keycode_rx #(.TIMEOUT_CYCLES(10000), .TMO_W(14)) dut (
      .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .key_event(key_event), .frame_err(frame_err)
   );

   always #5 Clk = ~Clk;

   int cyc = 0, n_ev = 0, n_err = 0, ev_cyc = -1, stop_cyc = 0;
   int nvec = 0, nmis = 0;

   always @(posedge Clk) cyc <= cyc + 1;
   always @(negedge Clk) begin
      if (key_event === 1'b1) begin n_ev <= n_ev + 1; ev_cyc <= cyc; end
      if (frame_err === 1'b1) n_err <= n_err + 1;
   end

   // reference model state
   logic [7:0]  map_n [logic [7:0]];
   logic [7:0]  map_e [logic [7:0]];
   logic [7:0]  pool [0:12];
   logic [15:0] m_key = 16'h0;
   logic        m_brk = 1'b0, m_ext = 1'b0;
   int          m_ev = 0, m_err = 0;

   function automatic logic [7:0] ref_hid(input logic e, input logic [7:0] s);
      if (e) return map_e.exists(s) ? map_e[s] : 8'h00;
      return map_n.exists(s) ? map_n[s] : 8'h00;
   endfunction

   task automatic model_byte(input logic [7:0] b, input logic badpar);
      logic [7:0]  h;
      logic [15:0] nk;
`ifdef PS2_PARITY_CHECK_EN
      if (badpar) begin m_err++; return; end
`endif
      if (b == 8'hF0)      m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
         h  = ref_hid(m_ext, b);
         nk = m_key;
         if (h != 8'h00) begin
            if (!m_brk)                   nk = {8'h00, h};
            else if (m_key == {8'h00, h}) nk = 16'h0;
         end
         if (nk != m_key) m_ev++;
         m_key = nk;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic badpar);
      return {1'b1, (~^b) ^ badpar, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ps2_data = f[i];
         tick(HALF);
         ps2_clk  = 1'b0;
         stop_cyc = cyc;
         tick(HALF);
         ps2_clk  = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic frame(input string tag, input logic [7:0] b, input logic badpar);
      send_bits(mk_frame(b, badpar), 0, 10);
      model_byte(b, badpar);
      tick(10);
      chk({tag, "_key"}, keycode, m_key);
      chk({tag, "_ev"}, n_ev, m_ev);
      chk({tag, "_err"}, n_err, m_err);
   endtask

   initial begin
      int e0;
      logic [7:0] b;
      map_n[8'h1C] = 8'h04; map_n[8'h23] = 8'h07; map_n[8'h1B] = 8'h16;
      map_n[8'h1D] = 8'h1A; map_n[8'h29] = 8'h2C; map_n[8'h5A] = 8'h28;
      map_n[8'h76] = 8'h29;
      map_e[8'h75] = 8'h52; map_e[8'h72] = 8'h51; map_e[8'h6B] = 8'h50;
      map_e[8'h74] = 8'h4F;
      pool = '{8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29, 8'h5A, 8'h76,
               8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0};

      tick(3);
      Reset = 1'b0;
      tick(2);
      chk("rst_key", keycode, 16'h0);
      chk("rst_ev", key_event, 1'b0);
      chk("rst_err", frame_err, 1'b0);

      frame("a_make", 8'h1C, 1'b0);
      chk("a_latency", ev_cyc - stop_cyc, 5);

      frame("a_repeat", 8'h1C, 1'b0);
      frame("a_brk_pfx", 8'hF0, 1'b0);
      frame("a_brk", 8'h1C, 1'b0);

      frame("up_pfx", 8'hE0, 1'b0);
      frame("up_make", 8'h75, 1'b0);
      frame("up_bpfx_e", 8'hE0, 1'b0);
      frame("up_bpfx_f", 8'hF0, 1'b0);
      frame("up_brk", 8'h75, 1'b0);

      frame("w_make", 8'h1D, 1'b0);
      frame("d_make", 8'h23, 1'b0);
      frame("w_bpfx", 8'hF0, 1'b0);
      frame("w_brk", 8'h1D, 1'b0);

      frame("s_badpar", 8'h1B, 1'b1);

      frame("pre_stall", 8'h1C, 1'b0);
      send_bits(mk_frame(8'h23, 1'b0), 0, 4);
      tick(12000);
      m_err++;
      chk("stall_err", n_err, m_err);
      chk("stall_key", keycode, m_key);
      frame("post_stall", 8'h23, 1'b0);

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
         else                           b = pool[$urandom_range(0, 12)];
         frame("rand", b, ($urandom_range(0, 7) == 0));
      end

      frame("pre_rst1", 8'h1C, 1'b0);
      frame("pre_rst2", 8'h1C, 1'b0);
      e0 = n_err;
      send_bits(mk_frame(8'h1C, 1'b0), 0, 4);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      m_key = 16'h0; m_brk = 1'b0; m_ext = 1'b0;
      tick(2);
      chk("rstmid_key", keycode, 16'h0);
      send_bits(mk_frame(8'h1C, 1'b0), 5, 10);
      tick(10100);
      chk("rstmid_tail_key", keycode, 16'h0);
      chk("rstmid_tail_ev", n_ev, m_ev);
      chk("rstmid_tail_err", (n_err > e0), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
